fp_writeback_ctrl: RTL and testbench
====================================

Name: fp_writeback_ctrl

Overview:
- Consumer side of the FP ALU execution units: collects results from the AddSub, Mul, Div and Sqrt pipelines and from the two Abs/Opp paths.
- Tags each result with its destination register and serialises all results onto the single FP register-file write port.
- Keeps a per-register pending scoreboard for issue hazard checks.
- Uses credit-based issue stalling, so results are never lost.

Parameters:
- FPRegWidth, 43, FP word width.
- RegAddrWidth, 5, register address width; NumRegs = 2**RegAddrWidth.
- AddSubLat, 8, AddSub pipeline latency in clocks (≥1).
- MulLat, 6, Mul pipeline latency (≥1).
- DivLat, 20, Div pipeline latency (≥1).
- SqrtLat, 20, Sqrt pipeline latency (≥1).
- WbDepth, 16, result FIFO depth (≥8, power of 2).

Ports:
- clock  in  1  single clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- AddSubIssue, MulIssue, DivIssue, SqrtIssue, AbsOpp1Issue, AbsOpp2Issue  in  1 each  op issued to that unit this cycle.
- AddSubDst, MulDst, DivDst, SqrtDst, AbsOpp1Dst, AbsOpp2Dst  in  RegAddrWidth each  destination register of the issued op.
- AddSubOut, MulOut, DivOut, SqrtOut, AbsOpp1Out, AbsOpp2Out  in  FPRegWidth each  unit result buses.
- IssueStall  out  1  no new issue allowed this cycle.
- RegWrEn  out  1  register-file write strobe.
- RegWrAddr  out  RegAddrWidth  write address.
- RegWrData  out  FPRegWidth  write data.
- Pending  out  NumRegs  bit r = register r has an outstanding result.
- ProtoErr  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: all outputs 0, FIFO empty, tag pipes invalid, Outstanding = 0. Reset is asynchronous, so in-flight ops are discarded immediately.
- Tag pipes: each pipelined unit has a valid+Dst shift register of length Lat. An issue sampled at edge t emerges at edge t+Lat, and XxxOut is sampled at that same edge.
- Abs/Opp paths are combinational: AbsOppNOut is captured at the issue edge t.
- Completions: up to 6 per edge, all enqueued into the FIFO at that edge in fixed order AbsOpp1, AbsOpp2, AddSub, Mul, Div, Sqrt.
- FIFO is show-ahead:
  - RegWrEn = FIFO non-empty; RegWrAddr and RegWrData = head.
  - Head pops at every edge where RegWrEn = 1.
  - Minimum latency: issue at edge t, RegWrEn high during cycle t+Lat, write committed at edge t+Lat+1. Abs: committed at edge t+1.
- Credits:
  - Outstanding counts in-flight plus queued results.
  - Each edge: +(number of accepted issues), −1 if a pop occurs; both may apply in the same edge.
  - IssueStall = (Outstanding + 6 > WbDepth), computed combinationally from registered Outstanding.
  - This guarantees the FIFO never overflows.
- Issue acceptance: an issue is accepted only when IssueStall = 0.
  - Issue while IssueStall = 1 is ignored and sets ProtoErr.
- Scoreboard:
  - Pending[d] is set on an accepted issue to d.
  - Pending[d] is cleared at the edge that pops a write to d.
  - If set and clear for the same register coincide, set wins.
  - Issue to a register already Pending, or two same-cycle issues to the same Dst: the op is still accepted and written in FIFO order, but ProtoErr is set.
- ProtoErr is sticky until reset.
- Priority is fixed, with no reordering: writes reach the register file in FIFO order.

Test Plan:
- Single add: AddSubIssue at edge 0, Dst = 3, AddSubOut = 43'h1_2345_6789 at edge 8 → RegWrEn = 1, RegWrAddr = 3, RegWrData = 43'h1_2345_6789 during cycle 8 only; Pending[3] = 1 from edge 0 through edge 9.
- Simultaneous completions: AbsOpp1Issue Dst = 1 and AbsOpp2Issue Dst = 2 at edge 0 → writes to reg 1 in cycle 0 and reg 2 in cycle 1, each with its respective data.
- Same-edge collision: MulIssue at edge 2 and AddSubIssue at edge 0 (both complete at edge 8) → AddSub result is written first, then Mul.
- Credits (WbDepth = 16): 11 Div issues on consecutive cycles → IssueStall rises once Outstanding = 11; a further issue is ignored and ProtoErr = 1; IssueStall drops after the first pop brings Outstanding to 10.
- Hazard: two SqrtIssue to Dst 5, 3 cycles apart → ProtoErr = 1, both results are written to reg 5 in order, and Pending[5] clears after the first pop.
- Reset mid-flight: nReset low 5 cycles after a DivIssue → all outputs 0 immediately; no write occurs after release; Outstanding = 0, so IssueStall = 0.

Source files
------------

// File: rtl/fp_writeback_ctrl.sv
// FP ALU writeback controller: tags unit results with their destination, serialises them
// onto the single register-file write port and tracks per-register pending state.

module fp_wb_tag_pipe #(
  parameter int Lat  = 1,
  parameter int DstW = 5
) (
  input  logic            clock,
  input  logic            nReset,
  input  logic            inValid,
  input  logic [DstW-1:0] inDst,
  output logic            outValid,
  output logic [DstW-1:0] outDst
);
  logic [Lat-1:0]  vld;
  logic [DstW-1:0] dst [Lat];

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      vld <= '0;
      for (int i = 0; i < Lat; i++) dst[i] <= '0;
    end else begin
      vld[0] <= inValid;
      dst[0] <= inDst;
      for (int i = 1; i < Lat; i++) begin
        vld[i] <= vld[i-1];
        dst[i] <= dst[i-1];
      end
    end
  end

  assign outValid = vld[Lat-1];
  assign outDst   = dst[Lat-1];
endmodule

module fp_writeback_ctrl #(
  parameter int FPRegWidth   = 43,
  parameter int RegAddrWidth = 5,
  parameter int AddSubLat    = 8,
  parameter int MulLat       = 6,
  parameter int DivLat       = 20,
  parameter int SqrtLat      = 20,
  parameter int WbDepth      = 16
) (
  input  logic                      clock,
  input  logic                      nReset,
  input  logic                      AddSubIssue,
  input  logic                      MulIssue,
  input  logic                      DivIssue,
  input  logic                      SqrtIssue,
  input  logic                      AbsOpp1Issue,
  input  logic                      AbsOpp2Issue,
  input  logic [RegAddrWidth-1:0]   AddSubDst,
  input  logic [RegAddrWidth-1:0]   MulDst,
  input  logic [RegAddrWidth-1:0]   DivDst,
  input  logic [RegAddrWidth-1:0]   SqrtDst,
  input  logic [RegAddrWidth-1:0]   AbsOpp1Dst,
  input  logic [RegAddrWidth-1:0]   AbsOpp2Dst,
  input  logic [FPRegWidth-1:0]     AddSubOut,
  input  logic [FPRegWidth-1:0]     MulOut,
  input  logic [FPRegWidth-1:0]     DivOut,
  input  logic [FPRegWidth-1:0]     SqrtOut,
  input  logic [FPRegWidth-1:0]     AbsOpp1Out,
  input  logic [FPRegWidth-1:0]     AbsOpp2Out,
  output logic                      IssueStall,
  output logic                      RegWrEn,
  output logic [RegAddrWidth-1:0]   RegWrAddr,
  output logic [FPRegWidth-1:0]     RegWrData,
  output logic [2**RegAddrWidth-1:0] Pending,
  output logic                      ProtoErr
);
  localparam int NumRegs = 2**RegAddrWidth;
  localparam int NumSrc  = 6;
  localparam int PtrW    = $clog2(WbDepth);
  localparam int CntW    = PtrW + 1;
  localparam int EntryW  = RegAddrWidth + FPRegWidth;

  // Source index order is also the enqueue order: AbsOpp1, AbsOpp2, AddSub, Mul, Div, Sqrt
  logic [NumSrc-1:0]       issueReq, issueAcc;
  logic [RegAddrWidth-1:0] issueDst [NumSrc];

  logic [NumSrc-1:0]       compValid;
  logic [RegAddrWidth-1:0] compDst  [NumSrc];
  logic [FPRegWidth-1:0]   compData [NumSrc];
  logic [PtrW-1:0]         compIdx  [NumSrc];

  logic [EntryW-1:0]       mem [WbDepth];
  logic [PtrW-1:0]         wrPtr, rdPtr;
  logic [CntW-1:0]         fifoCount, numComp, numIssue, outstanding;
  logic                    pop;
  logic [EntryW-1:0]       head;
  logic [NumRegs-1:0]      pendingNext;
  logic                    protoHit;

  assign issueReq = {SqrtIssue, DivIssue, MulIssue, AddSubIssue, AbsOpp2Issue, AbsOpp1Issue};
  assign issueAcc = IssueStall ? '0 : issueReq;

  always_comb begin
    issueDst[0] = AbsOpp1Dst;
    issueDst[1] = AbsOpp2Dst;
    issueDst[2] = AddSubDst;
    issueDst[3] = MulDst;
    issueDst[4] = DivDst;
    issueDst[5] = SqrtDst;
  end

  fp_wb_tag_pipe #(.Lat(AddSubLat), .DstW(RegAddrWidth)) uAddSubPipe (
    .clock(clock), .nReset(nReset), .inValid(issueAcc[2]), .inDst(AddSubDst),
    .outValid(compValid[2]), .outDst(compDst[2]));
  fp_wb_tag_pipe #(.Lat(MulLat), .DstW(RegAddrWidth)) uMulPipe (
    .clock(clock), .nReset(nReset), .inValid(issueAcc[3]), .inDst(MulDst),
    .outValid(compValid[3]), .outDst(compDst[3]));
  fp_wb_tag_pipe #(.Lat(DivLat), .DstW(RegAddrWidth)) uDivPipe (
    .clock(clock), .nReset(nReset), .inValid(issueAcc[4]), .inDst(DivDst),
    .outValid(compValid[4]), .outDst(compDst[4]));
  fp_wb_tag_pipe #(.Lat(SqrtLat), .DstW(RegAddrWidth)) uSqrtPipe (
    .clock(clock), .nReset(nReset), .inValid(issueAcc[5]), .inDst(SqrtDst),
    .outValid(compValid[5]), .outDst(compDst[5]));

  // Abs/Opp are combinational, so their results complete at the issue edge itself
  assign compValid[0] = issueAcc[0];
  assign compValid[1] = issueAcc[1];
  assign compDst[0]   = AbsOpp1Dst;
  assign compDst[1]   = AbsOpp2Dst;

  always_comb begin
    compData[0] = AbsOpp1Out;
    compData[1] = AbsOpp2Out;
    compData[2] = AddSubOut;
    compData[3] = MulOut;
    compData[4] = DivOut;
    compData[5] = SqrtOut;
  end

  // Pack this edge's completions into consecutive FIFO slots
  always_comb begin
    logic [PtrW-1:0] slot;
    slot     = wrPtr;
    numComp  = '0;
    numIssue = '0;
    for (int i = 0; i < NumSrc; i++) begin
      compIdx[i] = slot;
      if (compValid[i]) begin
        slot    = slot + PtrW'(1);
        numComp = numComp + CntW'(1);
      end
      numIssue = numIssue + CntW'(issueAcc[i]);
    end
  end

  assign pop        = (fifoCount != '0);
  assign head       = mem[rdPtr];
  assign RegWrEn    = pop;
  assign RegWrAddr  = pop ? head[EntryW-1:FPRegWidth] : '0;
  assign RegWrData  = pop ? head[FPRegWidth-1:0]      : '0;
  assign IssueStall = (outstanding > CntW'(WbDepth - NumSrc));

  always_ff @(posedge clock) begin
    for (int i = 0; i < NumSrc; i++)
      if (compValid[i]) mem[compIdx[i]] <= {compDst[i], compData[i]};
  end

  always_comb begin
    protoHit = |issueReq & IssueStall;
    for (int i = 0; i < NumSrc; i++) begin
      if (issueAcc[i] && Pending[issueDst[i]]) protoHit = 1'b1;
      for (int j = 0; j < i; j++)
        if (issueAcc[i] && issueAcc[j] && (issueDst[i] == issueDst[j])) protoHit = 1'b1;
    end
  end

  // Clear on pop first so a coincident set for the same register wins
  always_comb begin
    pendingNext = Pending;
    if (pop) pendingNext[head[EntryW-1:FPRegWidth]] = 1'b0;
    for (int i = 0; i < NumSrc; i++)
      if (issueAcc[i]) pendingNext[issueDst[i]] = 1'b1;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      outstanding <= '0;
      Pending     <= '0;
      ProtoErr    <= 1'b0;
    end else begin
      wrPtr       <= wrPtr + numComp[PtrW-1:0];
      rdPtr       <= rdPtr + PtrW'(pop);
      fifoCount   <= fifoCount + numComp - CntW'(pop);
      outstanding <= outstanding + numIssue - CntW'(pop);
      Pending     <= pendingNext;
      if (protoHit) ProtoErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_writeback_ctrl.sv
// Scoreboard bench for fp_writeback_ctrl: directed issues push expected writes,
// a negedge monitor pops and compares every register-file write.

module tb_fp_writeback_ctrl;
  localparam int FW = 43;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
    logic [31:0]   due;
  } wbItem_t;

  logic clock, nReset;
  logic AddSubIssue, MulIssue, DivIssue, SqrtIssue, AbsOpp1Issue, AbsOpp2Issue;
  logic [AW-1:0] AddSubDst, MulDst, DivDst, SqrtDst, AbsOpp1Dst, AbsOpp2Dst;
  logic [FW-1:0] AddSubOut, MulOut, DivOut, SqrtOut, AbsOpp1Out, AbsOpp2Out;
  logic IssueStall, RegWrEn, ProtoErr;
  logic [AW-1:0] RegWrAddr;
  logic [FW-1:0] RegWrData;
  logic [31:0]   Pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wbItem_t expQ[$];

  fp_writeback_ctrl dut (
    .clock(clock), .nReset(nReset),
    .AddSubIssue(AddSubIssue), .MulIssue(MulIssue), .DivIssue(DivIssue),
    .SqrtIssue(SqrtIssue), .AbsOpp1Issue(AbsOpp1Issue), .AbsOpp2Issue(AbsOpp2Issue),
    .AddSubDst(AddSubDst), .MulDst(MulDst), .DivDst(DivDst), .SqrtDst(SqrtDst),
    .AbsOpp1Dst(AbsOpp1Dst), .AbsOpp2Dst(AbsOpp2Dst),
    .AddSubOut(AddSubOut), .MulOut(MulOut), .DivOut(DivOut), .SqrtOut(SqrtOut),
    .AbsOpp1Out(AbsOpp1Out), .AbsOpp2Out(AbsOpp2Out),
    .IssueStall(IssueStall), .RegWrEn(RegWrEn), .RegWrAddr(RegWrAddr),
    .RegWrData(RegWrData), .Pending(Pending), .ProtoErr(ProtoErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectWr(input int addr, input logic [FW-1:0] data, input int due);
    wbItem_t it;
    it.addr = AW'(addr);
    it.data = data;
    it.due  = due;
    expQ.push_back(it);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      cyc++;
      #1;
    end
  endtask

  task automatic clearIssues();
    AddSubIssue = 0; MulIssue = 0; DivIssue = 0;
    SqrtIssue = 0; AbsOpp1Issue = 0; AbsOpp2Issue = 0;
  endtask

  always @(negedge clock) begin
    if (nReset && RegWrEn) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: addr %0d data %0h cycle %0d", RegWrAddr, RegWrData, cyc);
      end else begin
        wbItem_t it;
        it = expQ.pop_front();
        chk("write addr", 64'(RegWrAddr), 64'(it.addr));
        chk("write data", 64'(RegWrData), 64'(it.data));
        chk("write cycle", 64'(cyc), 64'(it.due));
      end
    end
  end

  initial begin
    int e;
    clearIssues();
    AddSubDst = 0; MulDst = 0; DivDst = 0; SqrtDst = 0; AbsOpp1Dst = 0; AbsOpp2Dst = 0;
    AddSubOut = 0; MulOut = 0; DivOut = 0; SqrtOut = 0; AbsOpp1Out = 0; AbsOpp2Out = 0;
    nReset = 0;
    #12;
    chk("reset RegWrEn", 64'(RegWrEn), 0);
    chk("reset RegWrAddr", 64'(RegWrAddr), 0);
    chk("reset RegWrData", 64'(RegWrData), 0);
    chk("reset Pending", 64'(Pending), 0);
    chk("reset ProtoErr", 64'(ProtoErr), 0);
    chk("reset IssueStall", 64'(IssueStall), 0);
    @(posedge clock); #1;
    nReset = 1;

    // single add
    e = cyc + 1;
    AddSubOut = 43'h1_2345_6789; AddSubDst = 3; AddSubIssue = 1;
    expectWr(3, 43'h1_2345_6789, e + 8);
    step(1); AddSubIssue = 0;
    chk("add pending set", 64'(Pending[3]), 1);
    step(7);
    chk("add no early write", 64'(RegWrEn), 0);
    step(1);
    chk("add pending in write cycle", 64'(Pending[3]), 1);
    step(1);
    chk("add pending cleared", 64'(Pending[3]), 0);

    // two abs/opp completions on one edge
    e = cyc + 1;
    AbsOpp1Issue = 1; AbsOpp1Dst = 1; AbsOpp1Out = 43'h7_0000_0001;
    AbsOpp2Issue = 1; AbsOpp2Dst = 2; AbsOpp2Out = 43'h0_ABCD_0002;
    expectWr(1, 43'h7_0000_0001, e);
    expectWr(2, 43'h0_ABCD_0002, e + 1);
    step(1); clearIssues();
    chk("abs pending both", 64'(Pending), 64'h6);
    step(1);
    chk("abs pending after first pop", 64'(Pending), 64'h4);
    step(2);
    chk("abs pending drained", 64'(Pending), 0);

    // AddSub and Mul completing at the same edge
    e = cyc + 1;
    AddSubIssue = 1; AddSubDst = 8; AddSubOut = 43'h2_1111_0008;
    MulOut = 43'h3_2222_0009;
    expectWr(8, 43'h2_1111_0008, e + 8);
    expectWr(9, 43'h3_2222_0009, e + 9);
    step(1); AddSubIssue = 0;
    step(1);
    MulIssue = 1; MulDst = 9;
    step(1); MulIssue = 0;
    step(8);
    chk("collision no ProtoErr", 64'(ProtoErr), 0);
    chk("collision pending drained", 64'(Pending), 0);

    // issue hazard: two Sqrt ops to reg 5
    e = cyc + 1;
    expectWr(5, 43'h4_0000_00A5, e + 20);
    expectWr(5, 43'h5_0000_00B5, e + 23);
    SqrtDst = 5;
    for (int j = 0; j <= 25; j++) begin
      SqrtOut = (j <= 20) ? 43'h4_0000_00A5 : 43'h5_0000_00B5;
      SqrtIssue = (j == 0 || j == 3);
      step(1);
      if (j == 0)  chk("hazard ProtoErr before", 64'(ProtoErr), 0);
      if (j == 3)  chk("hazard ProtoErr set", 64'(ProtoErr), 1);
      if (j == 20) chk("hazard pending before pop", 64'(Pending[5]), 1);
      if (j == 21) chk("hazard pending after pop", 64'(Pending[5]), 0);
    end
    SqrtIssue = 0;

    // reset with a Div op in flight
    e = cyc + 1;
    DivIssue = 1; DivDst = 7; DivOut = 43'h6_DEAD_0007;
    step(1); DivIssue = 0;
    chk("rst pending before", 64'(Pending[7]), 1);
    step(5);
    #2 nReset = 0;
    #1;
    chk("rst RegWrEn", 64'(RegWrEn), 0);
    chk("rst RegWrData", 64'(RegWrData), 0);
    chk("rst Pending", 64'(Pending), 0);
    chk("rst ProtoErr", 64'(ProtoErr), 0);
    chk("rst IssueStall", 64'(IssueStall), 0);
    step(2);
    nReset = 1;
    step(25);
    chk("rst pending after release", 64'(Pending), 0);

    // credits: 11 Div issues then one while stalled
    e = cyc + 1;
    for (int j = 0; j <= 31; j++) begin
      DivOut = 43'h100 + 43'(j);
      DivIssue = (j < 12);
      DivDst = AW'(10 + j);
      if (j < 11) expectWr(10 + j, 43'h100 + 43'(20 + j), e + 20 + j);
      step(1);
      if (j == 9)  chk("credit no stall at 10", 64'(IssueStall), 0);
      if (j == 10) chk("credit stall at 11", 64'(IssueStall), 1);
      if (j == 10) chk("credit ProtoErr clean", 64'(ProtoErr), 0);
      if (j == 11) chk("credit ProtoErr on stalled issue", 64'(ProtoErr), 1);
      if (j == 11) chk("credit stalled issue ignored", 64'(Pending[21]), 0);
      if (j == 20) chk("credit stall before pop", 64'(IssueStall), 1);
      if (j == 21) chk("credit stall released", 64'(IssueStall), 0);
    end
    DivIssue = 0;
    step(2);

    chk("scoreboard drained", 64'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
